// File: rtl/rds_block_sync.sv
// rds_block_sync: receive-side RDS block synchronizer and group assembler.
// Finds 26-bit block boundaries from the offset-word checkwords, reports each
// block once locked, and emits complete error-free A/B/C(C')/D groups.
module rds_block_sync #(
    parameter int unsigned MAX_BAD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic [15:0] block_data,
    output logic [2:0]  block_offset,
    output logic        block_valid,
    output logic        block_err,
    output logic        synced,
    output logic [15:0] group_a,
    output logic [15:0] group_b,
    output logic [15:0] group_c,
    output logic [15:0] group_d,
    output logic        group_valid
);

    typedef enum logic [1:0] {ST_SEARCH, ST_PRESYNC, ST_SYNC} state_e;
    typedef enum logic [1:0] {POS_A, POS_B, POS_C, POS_D} pos_e;

    localparam logic [9:0] OFS_A  = 10'h0FC;
    localparam logic [9:0] OFS_B  = 10'h198;
    localparam logic [9:0] OFS_C  = 10'h168;
    localparam logic [9:0] OFS_CP = 10'h350;
    localparam logic [9:0] OFS_D  = 10'h1B4;

    localparam logic [2:0] CODE_A  = 3'd0;
    localparam logic [2:0] CODE_B  = 3'd1;
    localparam logic [2:0] CODE_C  = 3'd2;
    localparam logic [2:0] CODE_CP = 3'd3;
    localparam logic [2:0] CODE_D  = 3'd4;

    localparam logic [4:0] BIT_LAST  = 5'd25;
    localparam logic [3:0] MAX_BAD_C = 4'(MAX_BAD);

    // (d * x^10) mod g(x), g = x^10+x^8+x^7+x^5+x^4+x^3+1, bit-serial LFSR unrolled
    function automatic logic [9:0] crc10(input logic [15:0] d);
        logic [9:0] r;
        logic       fb;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            fb = d[15 - i] ^ r[9];
            r  = {r[8:0], 1'b0};
            if (fb) begin
                r = r ^ 10'h1B9;
            end
        end
        return r;
    endfunction

    function automatic pos_e next_pos(input pos_e p);
        return pos_e'(p + 2'd1);
    endfunction

    // Only 25 bits are stored: the oldest window bit is shifted out before it
    // could ever be observed, so the full 26-bit window exists only as sr_next.
    state_e      state_q, state_d;
    logic [24:0] sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;
    pos_e        expected_q, expected_d;
    logic [3:0]  bad_cnt_q, bad_cnt_d;
    logic        group_ok_q, group_ok_d;
    logic [15:0] word_a_q, word_a_d;
    logic [15:0] word_b_q, word_b_d;
    logic [15:0] word_c_q, word_c_d;

    logic [15:0] block_data_q, block_data_d;
    logic [2:0]  block_offset_q, block_offset_d;
    logic        block_valid_q, block_valid_d;
    logic        block_err_q, block_err_d;
    logic        synced_q, synced_d;
    logic [15:0] group_a_q, group_a_d;
    logic [15:0] group_b_q, group_b_d;
    logic [15:0] group_c_q, group_c_d;
    logic [15:0] group_d_q, group_d_d;
    logic        group_valid_q, group_valid_d;

    logic [25:0] sr_next;
    logic [9:0]  syndrome;
    logic        m_a, m_b, m_c, m_cp, m_d;
    logic        any_match;
    pos_e        matched_pos;
    logic        exp_match;
    logic [2:0]  exp_code;
    logic        at_boundary;
    logic        report;

    // Checkword evaluation of the window as it will be after this strobe
    always_comb begin
        sr_next     = {sr_q, bit_in};
        syndrome    = crc10(sr_next[25:10]) ^ sr_next[9:0];
        m_a         = (syndrome == OFS_A);
        m_b         = (syndrome == OFS_B);
        m_c         = (syndrome == OFS_C);
        m_cp        = (syndrome == OFS_CP);
        m_d         = (syndrome == OFS_D);
        any_match   = m_a | m_b | m_c | m_cp | m_d;
        matched_pos = POS_D;
        if (m_a) begin
            matched_pos = POS_A;
        end else if (m_b) begin
            matched_pos = POS_B;
        end else if (m_c | m_cp) begin
            matched_pos = POS_C;
        end
        exp_match = 1'b0;
        exp_code  = CODE_A;
        case (expected_q)
            POS_A: begin exp_match = m_a;        exp_code = CODE_A; end
            POS_B: begin exp_match = m_b;        exp_code = CODE_B; end
            POS_C: begin exp_match = m_c | m_cp; exp_code = m_cp ? CODE_CP : CODE_C; end
            POS_D: begin exp_match = m_d;        exp_code = CODE_D; end
            default: ;
        endcase
        at_boundary = bit_valid && (cnt_q == BIT_LAST);
        report      = at_boundary &&
                      ((state_q == ST_SYNC) || ((state_q == ST_PRESYNC) && exp_match));
    end

    // State register: all flops, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_SEARCH;
            sr_q           <= '0;
            cnt_q          <= '0;
            expected_q     <= POS_A;
            bad_cnt_q      <= '0;
            group_ok_q     <= 1'b0;
            word_a_q       <= '0;
            word_b_q       <= '0;
            word_c_q       <= '0;
            block_data_q   <= '0;
            block_offset_q <= '0;
            block_valid_q  <= 1'b0;
            block_err_q    <= 1'b0;
            synced_q       <= 1'b0;
            group_a_q      <= '0;
            group_b_q      <= '0;
            group_c_q      <= '0;
            group_d_q      <= '0;
            group_valid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            sr_q           <= sr_d;
            cnt_q          <= cnt_d;
            expected_q     <= expected_d;
            bad_cnt_q      <= bad_cnt_d;
            group_ok_q     <= group_ok_d;
            word_a_q       <= word_a_d;
            word_b_q       <= word_b_d;
            word_c_q       <= word_c_d;
            block_data_q   <= block_data_d;
            block_offset_q <= block_offset_d;
            block_valid_q  <= block_valid_d;
            block_err_q    <= block_err_d;
            synced_q       <= synced_d;
            group_a_q      <= group_a_d;
            group_b_q      <= group_b_d;
            group_c_q      <= group_c_d;
            group_d_q      <= group_d_d;
            group_valid_q  <= group_valid_d;
        end
    end

    // Next-state: SEARCH/PRESYNC/SYNC transitions, bit counter and expected offset
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        expected_d = expected_q;
        bad_cnt_d  = bad_cnt_q;
        if (bit_valid) begin
            sr_d = sr_next[24:0];
        end
        case (state_q)
            ST_SEARCH: begin
                if (bit_valid && any_match) begin
                    state_d    = ST_PRESYNC;
                    cnt_d      = '0;
                    expected_d = next_pos(matched_pos);
                end
            end
            ST_PRESYNC: begin
                if (at_boundary) begin
                    cnt_d = '0;
                    if (exp_match) begin
                        state_d    = ST_SYNC;
                        bad_cnt_d  = '0;
                        expected_d = next_pos(expected_q);
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end else if (bit_valid) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_SYNC: begin
                if (at_boundary) begin
                    cnt_d      = '0;
                    expected_d = next_pos(expected_q);
                    if (exp_match) begin
                        bad_cnt_d = '0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 4'd1;
                        if (bad_cnt_d == MAX_BAD_C) begin
                            state_d = ST_SEARCH;
                        end
                    end
                end else if (bit_valid) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Outputs: block reports, sync flag and group assembly
    always_comb begin
        block_data_d   = block_data_q;
        block_offset_d = block_offset_q;
        block_err_d    = block_err_q;
        block_valid_d  = 1'b0;
        synced_d       = (state_d == ST_SYNC);
        group_ok_d     = group_ok_q;
        word_a_d       = word_a_q;
        word_b_d       = word_b_q;
        word_c_d       = word_c_q;
        group_a_d      = group_a_q;
        group_b_d      = group_b_q;
        group_c_d      = group_c_q;
        group_d_d      = group_d_q;
        group_valid_d  = 1'b0;
        if (report) begin
            block_valid_d  = 1'b1;
            block_data_d   = sr_next[25:10];
            block_offset_d = exp_code;
            block_err_d    = ~exp_match;
        end
        if (report && (state_q == ST_PRESYNC)) begin
            // the acquiring group never started with an A seen in SYNC
            group_ok_d = 1'b0;
        end
        if (report && (state_q == ST_SYNC)) begin
            case (expected_q)
                POS_A: begin group_ok_d = exp_match;              word_a_d = sr_next[25:10]; end
                POS_B: begin group_ok_d = group_ok_q & exp_match; word_b_d = sr_next[25:10]; end
                POS_C: begin group_ok_d = group_ok_q & exp_match; word_c_d = sr_next[25:10]; end
                POS_D: begin
                    group_ok_d = group_ok_q & exp_match;
                    if (group_ok_q && exp_match) begin
                        group_valid_d = 1'b1;
                        group_a_d     = word_a_q;
                        group_b_d     = word_b_q;
                        group_c_d     = word_c_q;
                        group_d_d     = sr_next[25:10];
                    end
                end
                default: ;
            endcase
        end
    end

    assign block_data   = block_data_q;
    assign block_offset = block_offset_q;
    assign block_valid  = block_valid_q;
    assign block_err    = block_err_q;
    assign synced       = synced_q;
    assign group_a      = group_a_q;
    assign group_b      = group_b_q;
    assign group_c      = group_c_q;
    assign group_d      = group_d_q;
    assign group_valid  = group_valid_q;

endmodule

// File: tb/tb_rds_block_sync.sv
// Testbench for rds_block_sync: directed scenarios plus randomized group
// streams, checked every cycle against a behavioural model of the bitstream.
module tb_rds_block_sync;

    localparam int unsigned MB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic [15:0] block_data;
    logic [2:0]  block_offset;
    logic        block_valid;
    logic        block_err;
    logic        synced;
    logic [15:0] group_a, group_b, group_c, group_d;
    logic        group_valid;

    always #5 clk = ~clk;

    rds_block_sync #(.MAX_BAD(MB)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .block_data(block_data), .block_offset(block_offset),
        .block_valid(block_valid), .block_err(block_err), .synced(synced),
        .group_a(group_a), .group_b(group_b), .group_c(group_c), .group_d(group_d),
        .group_valid(group_valid)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Syndrome of a whole 26-bit word by polynomial long division: a window
    // {d, c} carries offset X exactly when (window mod g) == X.
    function automatic logic [9:0] mod_g(input logic [25:0] w);
        logic [25:0] r;
        r = w;
        for (int i = 25; i >= 10; i--)
            if (r[i]) r = r ^ (26'h5B9 << (i - 10));
        return r[9:0];
    endfunction

    function automatic logic [9:0] ofs(input int code);
        case (code)
            0: return 10'h0FC;
            1: return 10'h198;
            2: return 10'h168;
            3: return 10'h350;
            default: return 10'h1B4;
        endcase
    endfunction

    function automatic int match_code(input logic [25:0] w);
        logic [9:0] s;
        s = mod_g(w);
        for (int k = 0; k < 5; k++) if (s == ofs(k)) return k;
        return -1;
    endfunction

    function automatic int pos_of(input int code);
        return (code < 2) ? code : (code < 4) ? 2 : 3;
    endfunction

    function automatic logic [25:0] enc(input logic [15:0] d, input int code);
        return {d, mod_g({d, 10'b0}) ^ ofs(code)};
    endfunction

    int          m_mode = 0;   // 0 search, 1 presync, 2 sync
    int          m_cnt = 0, m_exp = 0, m_bad = 0;
    bit          m_gok = 0;
    logic [25:0] m_win = '0;
    logic [15:0] m_words [4];
    logic        m_bv = 0, m_berr = 0, m_synced = 0, m_gv = 0;
    logic [2:0]  m_boff = '0;
    logic [15:0] m_bdata = '0, m_ga = '0, m_gb = '0, m_gc = '0, m_gd = '0;

    always @(posedge clk) begin
        int  k;
        bit  good;
        m_bv = 0;
        m_gv = 0;
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_exp = 0; m_bad = 0; m_gok = 0; m_win = '0;
            m_berr = 0; m_boff = '0; m_bdata = '0;
            m_ga = '0; m_gb = '0; m_gc = '0; m_gd = '0;
        end else if (bit_valid) begin
            m_win = {m_win[24:0], bit_in};
            k = match_code(m_win);
            if (m_mode == 0) begin
                if (k >= 0) begin
                    m_mode = 1; m_cnt = 0; m_exp = (pos_of(k) + 1) % 4;
                end
            end else begin
                m_cnt++;
                if (m_cnt == 26) begin
                    m_cnt = 0;
                    good = (k >= 0) && (pos_of(k) == m_exp);
                    if (m_mode == 1) begin
                        if (good) begin
                            m_mode = 2; m_bad = 0; m_gok = 0;
                            m_bv = 1; m_berr = 0; m_boff = 3'(k); m_bdata = m_win[25:10];
                            m_exp = (m_exp + 1) % 4;
                        end else begin
                            m_mode = 0;
                        end
                    end else begin
                        m_bv = 1; m_berr = !good; m_bdata = m_win[25:10];
                        m_boff = good ? 3'(k) : ((m_exp == 3) ? 3'd4 : 3'(m_exp));
                        m_words[m_exp] = m_win[25:10];
                        m_gok = (m_exp == 0) ? good : (m_gok && good);
                        if (m_exp == 3 && m_gok) begin
                            m_gv = 1;
                            m_ga = m_words[0]; m_gb = m_words[1]; m_gc = m_words[2]; m_gd = m_words[3];
                        end
                        if (good) m_bad = 0;
                        else begin
                            m_bad++;
                            if (m_bad == int'(MB)) m_mode = 0;
                        end
                        m_exp = (m_exp + 1) % 4;
                    end
                end
            end
        end
        m_synced = (m_mode == 2);
    end

    // ---------------- per-cycle compare ----------------
    bit          cap_en = 0, cap_seen = 0;
    logic [2:0]  cap_off = '0;
    logic        cap_err = 0, cap_sync = 0;
    int unsigned gv_count = 0;

    always @(negedge clk) begin
        check("blk", {block_valid, block_err, block_offset, block_data},
                     {m_bv, m_berr, m_boff, m_bdata});
        check("sync", synced, m_synced);
        check("grp_valid", group_valid, m_gv);
        check("grp_words", {group_a, group_b, group_c, group_d}, {m_ga, m_gb, m_gc, m_gd});
        if (cap_en && block_valid && !cap_seen) begin
            cap_seen = 1; cap_off = block_offset; cap_err = block_err; cap_sync = synced;
        end
        if (cap_en && group_valid) gv_count++;
    end

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_in = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_word(input logic [25:0] w, input int nbits);
        for (int i = 25; i > 25 - nbits; i--) send_bit(w[i]);
    endtask

    task automatic send_group(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d,
                              input bit cp, input int bad_blk, input int bad_bit);
        logic [25:0] w [4];
        w[0] = enc(a, 0);
        w[1] = enc(b, 1);
        w[2] = enc(c, cp ? 3 : 2);
        w[3] = enc(d, 4);
        for (int k = 0; k < 4; k++) begin
            logic [25:0] x;
            x = w[k];
            if (k == bad_blk) x[bad_bit] = ~x[bad_bit];
            send_word(x, 26);
        end
    endtask

    task automatic std_group();
        send_group(16'h1234, 16'h0408, 16'hE0CD, 16'h4142, 0, -1, 0);
    endtask

    initial begin
        logic [25:0] wd;
        // reset held with strobes on bit_in=1
        repeat (5) begin
            @(negedge clk);
            bit_in = 1'b1;
            bit_valid = 1'b1;
        end
        check("rst_blk", {block_valid, block_err, block_offset, block_data, synced}, '0);
        check("rst_grp", {group_a, group_b, group_c, group_d}, '0);
        check("rst_gv", group_valid, 1'b0);
        @(negedge clk);
        bit_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // pin the model's checkword arithmetic with hand-computed values
        check("crc_x10", mod_g(26'h400), 10'h1B9);
        check("crc_1234", mod_g({16'h1234, 10'b0}), 10'h096);

        // clean lock
        cap_en = 1; cap_seen = 0; gv_count = 0;
        repeat (100) send_bit(1'b0);
        repeat (3) std_group();
        repeat (3) @(negedge clk);
        cap_en = 0;
        check("lock_first_off", cap_off, 3'd1);
        check("lock_first_err", cap_err, 1'b0);
        check("lock_first_sync", cap_sync, 1'b1);
        check("lock_gv_count", gv_count, 2);
        check("lock_words", {group_a, group_b, group_c, group_d}, 64'h1234_0408_E0CD_4142);

        // C' group
        cap_en = 1; gv_count = 0;
        send_group(16'h1234, 16'h0C00, 16'h1234, 16'h5566, 1, -1, 0);
        repeat (3) @(negedge clk);
        cap_en = 0;
        check("cp_gv_count", gv_count, 1);
        check("cp_group_c", group_c, 16'h1234);

        // single-bit error in C, then a clean group
        cap_en = 1; gv_count = 0;
        send_group(16'h1234, 16'h0408, 16'hE0CD, 16'h4142, 0, 2, 7);
        check("err_synced", synced, 1'b1);
        check("err_gv_count", gv_count, 0);
        std_group();
        repeat (3) @(negedge clk);
        cap_en = 0;
        check("err_next_gv", gv_count, 1);

        // loss of sync via one inserted bit, then relock
        send_bit(1'b1);
        repeat (14) std_group();
        check("relock_synced", synced, 1'b1);

        // reset 13 bits into a D block while synced; strobe during reset dropped
        std_group();
        send_group(16'h1234, 16'h0408, 16'hE0CD, 16'h4142, 0, -1, 0);
        std_group();
        wd = enc(16'h4142, 4);
        send_word(enc(16'h1234, 0), 26);
        send_word(enc(16'h0408, 1), 26);
        send_word(enc(16'hE0CD, 2), 26);
        send_word(wd, 13);
        @(negedge clk);
        rst_n = 1'b0;
        bit_in = 1'b1;
        bit_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bit_valid = 1'b0;
        check("midrst_synced", synced, 1'b0);
        check("midrst_gv", group_valid, 1'b0);
        repeat (2) @(negedge clk);
        wd = wd << 13;
        send_word(wd, 13);
        repeat (4) std_group();
        check("midrst_relock", synced, 1'b1);

        // randomized groups with occasional bit errors and slips
        for (int g = 0; g < 30; g++) begin
            int bb;
            bb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            if ($urandom_range(0, 14) == 0) send_bit(1'($urandom_range(0, 1)));
            send_group(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                       1'($urandom_range(0, 1)), bb, int'($urandom_range(0, 25)));
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rds_block_sync.md
# rds_block_sync

Receive-side RDS block synchronizer and group assembler. It sits after the 57 kHz subcarrier demodulator and differential bit decoder in the receive path. It takes a serial RDS bitstream, finds the 26-bit block boundaries using the offset-word checkwords, and checks each block. It also assembles complete, error-free A/B/C(C′)/D groups for the downstream group parser. Error correction is out of scope; the block does detection only.

## Interface
- `MAX_BAD`, default 8: number of consecutive errored blocks in SYNC that forces a return to SEARCH (legal range 1..15).
- `clk` input 1: system clock; all logic sits on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `bit_in` input 1: received RDS data bit, sampled only when `bit_valid` is 1.
- `bit_valid` input 1: one-cycle strobe, one per received bit. At least 2 idle cycles between strobes.
- `block_data` output 16: information word of the last reported block.
- `block_offset` output 3: offset of the last reported block (0=A, 1=B, 2=C, 3=C′, 4=D).
- `block_valid` output 1: one-cycle pulse; the `block_*` outputs are updated in that cycle.
- `block_err` output 1: checkword mismatch on the last reported block.
- `synced` output 1: 1 while in SYNC.
- `group_a`, `group_b`, `group_c`, `group_d` output 16 each: the four information words of the last good group.
- `group_valid` output 1: one-cycle pulse; the `group_*` outputs are updated in that cycle.

## Operation
- Bits arrive MSB first. On each strobe the 26-bit window shifts left: `sr <= {sr[24:0], bit_in}`.
- **Checkword:**
  - `crc(d)` is (d·x¹⁰) mod g(x), with g(x)=x¹⁰+x⁸+x⁷+x⁵+x⁴+x³+1.
  - The window matches offset X iff `sr[9:0] == crc(sr[25:10]) ^ OFS_X`.
  - Offset values: A=0x0FC, B=0x198, C=0x168, C′=0x350, D=0x1B4.
  - Any compute style is acceptable (parallel XOR tree or bit-serial), provided the Timing rules hold.
- **Offset sequence:** A→B→(C or C′)→D→A. At the third position both C and C′ are accepted. The one that matches is reported.
- **States:**
  - SEARCH (reset state):
    - After every strobe, test the window against all five offsets.
    - On any match: load `expected = next(matched)`, clear the bit counter, and go to PRESYNC.
    - Nothing is reported in SEARCH.
  - PRESYNC:
    - Count strobes. On the 26th, test the window against `expected` only.
    - Match: go to SYNC and report that block with `block_err=0`.
    - Mismatch: go to SEARCH; window testing resumes from the next strobe.
  - SYNC:
    - Every 26th strobe, test against `expected`, report the block, and advance `expected`.
    - Reporting rules:
      - Good block: `bad_cnt` is cleared.
      - Bad block: `block_err=1`, `block_offset` is set to the expected offset (2 at the C/C′ position), and `block_data` is `sr[25:10]`.
      - Bad block: `bad_cnt` is incremented.
    - When `bad_cnt` reaches `MAX_BAD`, go to SEARCH. `synced` falls in the same cycle as that block's `block_valid`.
    - `expected` keeps advancing on bad blocks; block position is never re-derived in SYNC.
- **Group assembly** (SYNC only):
  - An A-position block clears `group_ok` and sets it to the A block's good status.
  - Each later position ANDs its good status into `group_ok`.
  - On the D-position block, if `group_ok` is 1, latch all four words into `group_*` and pulse `group_valid`.
  - Any group not started with an A block reported in SYNC is discarded, including the group in which sync was acquired.
- **Reset** (any time):
  - Go to SEARCH; clear `sr`, counters, `expected`, `bad_cnt` and `group_ok`.
  - All outputs return to 0 on the next edge.
  - A strobe coinciding with `rst_n=0` is dropped.

## Timing
- Reset values: all outputs are 0.
- `block_valid` and `group_valid` assert exactly 1 clock after the `bit_valid` cycle that completes the block. They are high for one clock only.
- `block_*` and `group_*` hold their values until the next pulse.
- `group_valid` coincides with the D block's `block_valid`.
- State changes take effect on that same edge: `synced` rises with the `block_valid` of the confirming block.
- Minimum lock time: 52 strobes after the first block boundary, plus 1 clock.

## Test plan
- **Reset:** hold `rst_n=0` for 5 cycles with strobes on `bit_in=1` → all outputs 0, no pulses.
- **Clean lock:** 100 zero bits (cannot match, since every offset ≠ 0), then groups with PI=0x1234, B=0x0408, C=0xE0CD, D=0x4142, repeated.
  - The first block_valid is the B block (offset 1, err 0, `synced` rising).
  - C (2) and D (4) follow, and no `group_valid` occurs for that first group.
  - The next D block pulses `group_valid` with the four words above.
- **C′ handling:** a type-B group with C′ block data 0x1234 → `block_offset=3`, `block_err=0`, `group_valid` at D with `group_c=0x1234`.
- **Single-bit error:** in SYNC, flip bit 7 of one C block → that report has `block_err=1`; no `group_valid` for that group; `synced` stays 1; the next group is valid.
- **Loss of sync:** in SYNC, insert one extra bit into the stream → errored blocks follow; on the 8th, `synced` falls in the same cycle as its `block_valid`. Lock is then reacquired within 52 strobes of the next boundary.
- **Reset mid-block:** pulse `rst_n=0` for one cycle 13 bits into a D block while synced → `synced=0` on the next edge; no `group_valid`; relock follows from SEARCH.
